// File: rtl/demux4way16_stream.sv
// demux4way16_stream: one input stream steered by in_sel into four
// independently drained lanes, each backed by a small FIFO.

// Per-lane FIFO: registered head, occupancy-based valid/full flags.
module demux4way16_lane #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0]               rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]                 count_q, count_d;
  logic                        pop;

  assign valid = (count_q != '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  // A pop needs a word present; out_ready on an empty lane does nothing.
  assign pop   = valid && rd_en;
  // Head comes straight from storage, forced to zero while the lane is empty.
  assign head  = valid ? mem_q[rd_ptr_q] : '0;

  // Next-state for storage, pointers (wrap mod DEPTH) and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Lane state; reset discards every buffered word at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

module demux4way16_stream #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [15:0]        routed_count
);
  logic [3:0]            full;
  logic [3:0]            push;
  logic [3:0][WIDTH-1:0] head;
  logic                  accept;
  logic [15:0]           routed_count_q, routed_count_d;

  // Ready looks only at the selected lane's registered fullness, so a
  // same-cycle pop on a full lane never opens it (no pass-through).
  assign in_ready = !reset && !full[in_sel];
  assign accept   = in_valid && in_ready;

  // Steer an accepted word to the selected lane only.
  always_comb begin
    push = '0;
    if (accept) push[in_sel] = 1'b1;
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    demux4way16_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .push    (push[i]),
      .wr_data (in_data),
      .rd_en   (out_ready[i]),
      .head    (head[i]),
      .valid   (out_valid[i]),
      .full    (full[i])
    );
  end

  // Lane i lands in bits [i*WIDTH +: WIDTH] of the packed head array.
  assign out_data = head;

  // Accepted-word counter, wraps naturally at 16 bits.
  always_comb routed_count_d = routed_count_q + (accept ? 16'd1 : 16'd0);

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) routed_count_q <= '0;
    else       routed_count_q <= routed_count_d;
  end

  assign routed_count = routed_count_q;
endmodule

// File: tb/tb_demux4way16_stream.sv
module tb_demux4way16_stream;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in_data = '0;
  logic [1:0]  in_sel = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = '0;
  logic [15:0] routed_count;

  int n_cmp = 0;
  int n_fail = 0;

  demux4way16_stream #(.WIDTH(16), .DEPTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_sel       (in_sel),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .routed_count (routed_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [1:0]  sel;
    logic [15:0] data;
    logic [3:0]  ordy;
    logic        exp_rdy;   // in_ready before the edge
    logic [3:0]  exp_ov;    // after the edge
    logic [63:0] exp_od;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [1:0] s, input logic [15:0] d,
                              input logic [3:0] r, input logic er, input logic [3:0] eov,
                              input logic [63:0] eod, input logic [15:0] ec);
    vec_t t;
    t.vld = v; t.sel = s; t.data = d; t.ordy = r;
    t.exp_rdy = er; t.exp_ov = eov; t.exp_od = eod; t.exp_cnt = ec;
    return t;
  endfunction

  // Drive on the falling edge, check ready, clock, then check outputs.
  task automatic step(input vec_t v, input int idx);
    @(negedge clk);
    in_valid = v.vld; in_sel = v.sel; in_data = v.data; out_ready = v.ordy;
    #1;
    check($sformatf("v%0d in_ready", idx), {63'd0, in_ready}, {63'd0, v.exp_rdy});
    @(posedge clk);
    #1;
    check($sformatf("v%0d out_valid", idx), {60'd0, out_valid}, {60'd0, v.exp_ov});
    check($sformatf("v%0d out_data", idx), out_data, v.exp_od);
    check($sformatf("v%0d routed_count", idx), {48'd0, routed_count}, {48'd0, v.exp_cnt});
  endtask

  initial begin
    //           vld sel data     ordy     rdy ov       out_data (d,c,b,a)       cnt
    vecs[0]  = mk(1, 2, 16'h1234, 4'b0000, 1, 4'b0100, 64'h0000_1234_0000_0000, 1);
    vecs[1]  = mk(0, 0, 16'h0000, 4'b0100, 1, 4'b0000, 64'h0000_0000_0000_0000, 1);
    vecs[2]  = mk(1, 0, 16'hAAAA, 4'b0000, 1, 4'b0001, 64'h0000_0000_0000_AAAA, 2);
    vecs[3]  = mk(1, 0, 16'hBBBB, 4'b0000, 1, 4'b0001, 64'h0000_0000_0000_AAAA, 3);
    vecs[4]  = mk(1, 0, 16'hDDDD, 4'b0000, 0, 4'b0001, 64'h0000_0000_0000_AAAA, 3);
    vecs[5]  = mk(1, 1, 16'hCCCC, 4'b0000, 1, 4'b0011, 64'h0000_0000_CCCC_AAAA, 4);
    vecs[6]  = mk(1, 0, 16'hEEEE, 4'b0001, 0, 4'b0011, 64'h0000_0000_CCCC_BBBB, 4);
    vecs[7]  = mk(0, 0, 16'h0000, 4'b0000, 1, 4'b0011, 64'h0000_0000_CCCC_BBBB, 4);
    vecs[8]  = mk(1, 0, 16'h1111, 4'b0001, 1, 4'b0011, 64'h0000_0000_CCCC_1111, 5);
    vecs[9]  = mk(1, 2, 16'h2222, 4'b0100, 1, 4'b0111, 64'h0000_2222_CCCC_1111, 6);
    vecs[10] = mk(1, 1, 16'h3333, 4'b0000, 1, 4'b0111, 64'h0000_2222_CCCC_1111, 7);
    vecs[11] = mk(1, 1, 16'h4444, 4'b0000, 0, 4'b0111, 64'h0000_2222_CCCC_1111, 7);
    vecs[12] = mk(1, 3, 16'h4444, 4'b0000, 1, 4'b1111, 64'h4444_2222_CCCC_1111, 8);
    vecs[13] = mk(0, 0, 16'h0000, 4'b1111, 1, 4'b0010, 64'h0000_0000_3333_0000, 8);
    vecs[14] = mk(0, 0, 16'h0000, 4'b0010, 1, 4'b0000, 64'h0000_0000_0000_0000, 8);

    // Reset state while reset is held
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst out_valid", {60'd0, out_valid}, 64'd0);
    check("rst out_data", out_data, 64'd0);
    check("rst in_ready", {63'd0, in_ready}, 64'd0);
    check("rst routed_count", {48'd0, routed_count}, 64'd0);
    reset = 1'b0;
    #1;
    check("post-rst in_ready", {63'd0, in_ready}, 64'd1);

    for (int i = 0; i < 15; i++) step(vecs[i], i);

    // Stream 8 words into lane d while it drains every cycle
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_sel = 2'd3; in_data = 16'hD000 + 16'(k); out_ready = 4'b1000;
      #1;
      check($sformatf("stream%0d in_ready", k), {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1;
      check($sformatf("stream%0d out_valid", k), {60'd0, out_valid}, 64'h8);
      check($sformatf("stream%0d head", k), {48'd0, out_data[63:48]}, {48'd0, 16'hD000 + 16'(k)});
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("stream drained", {60'd0, out_valid}, 64'd0);
    check("stream count", {48'd0, routed_count}, 64'd16);

    // Asynchronous reset mid-operation with lanes non-empty
    @(negedge clk);
    in_valid = 1'b1; in_sel = 2'd0; in_data = 16'h5A5A; out_ready = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    in_sel = 2'd1; in_data = 16'h6B6B;
    @(posedge clk);
    #1;
    check("pre-arst out_valid", {60'd0, out_valid}, 64'h3);
    #2;
    reset = 1'b1;
    #1;
    check("arst out_valid", {60'd0, out_valid}, 64'd0);
    check("arst out_data", out_data, 64'd0);
    check("arst in_ready", {63'd0, in_ready}, 64'd0);
    check("arst routed_count", {48'd0, routed_count}, 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst release in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    check("arst release out_valid", {60'd0, out_valid}, 64'd0);
    check("arst release count", {48'd0, routed_count}, 64'd0);

    // 65536 pushes wrap the counter
    @(negedge clk);
    in_valid = 1'b1; in_sel = 2'd0; in_data = 16'h0F0F; out_ready = 4'b0001;
    repeat (65535) @(posedge clk);
    #1;
    check("count 0xFFFF", {48'd0, routed_count}, 64'hFFFF);
    @(posedge clk);
    #1;
    check("count wrap", {48'd0, routed_count}, 64'd0);
    @(negedge clk);
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/demux4way16_stream.md
DEMUX4WAY16_STREAM -- requirements
Module: demux4way16_stream

Interface
REQ-001 Parameter: WIDTH, 16, data word width in bits.
REQ-002 Parameter: DEPTH, 2, entries per lane FIFO; power of two, 2 or greater.
REQ-003 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: in_data  input  WIDTH  word to route.
REQ-006 Port: in_sel  input  2  destination lane: 0=a, 1=b, 2=c, 3=d.
REQ-007 Port: in_valid  input  1  source offers in_data/in_sel this cycle.
REQ-008 Port: in_ready  output  1  block accepts the offered word this cycle.
REQ-009 Port: out_data  output  4*WIDTH  lane heads; lane i occupies bits [i*WIDTH +: WIDTH].
REQ-010 Port: out_valid  output  4  lane i has a word at its head.
REQ-011 Port: out_ready  input  4  sink i takes the lane i head this cycle.
REQ-012 Port: routed_count  output  16  total words accepted since reset.

Function
REQ-013 The block shall be the inverse of a 4-way 16-bit mux: one input stream, steered by in_sel, into four independent output lanes.
REQ-014 Each lane shall contain a DEPTH-entry FIFO with its own read pointer, write pointer and occupancy count.
REQ-015 in_ready shall equal NOT full(lane[in_sel]); it shall depend only on registered occupancy and in_sel, never on out_ready.
REQ-016 A push shall occur when in_valid and in_ready are both high; the word shall be written to lane[in_sel] only.
REQ-017 out_valid[i] shall equal (occupancy of lane i > 0).
REQ-018 out_data lane i shall drive the FIFO head, directly from registers; it shall be 0 while lane i is empty.
REQ-019 A pop of lane i shall occur when out_valid[i] and out_ready[i] are both high.
REQ-020 Latency: a word pushed in cycle N shall appear at its lane head (out_valid high) in cycle N+1 if the lane was empty.
REQ-021 Same-lane push and pop in one cycle on a non-full, non-empty lane shall leave occupancy unchanged, with both operations performed.
REQ-022 Full lane: in_ready shall be 0 even if that lane pops in the same cycle; there is no pass-through.
REQ-023 Empty lane: a push in the same cycle as out_ready high shall not pop; out_ready on an empty lane shall be ignored.
REQ-024 Pointers shall wrap modulo DEPTH; occupancy shall range 0..DEPTH.
REQ-025 Order shall be preserved within a lane; no ordering is implied across lanes.
REQ-026 Changing in_sel while in_valid is high and in_ready is low shall re-evaluate in_ready against the new lane; no word shall be lost or duplicated.
REQ-027 Once asserted, out_valid[i] shall stay high with stable data until popped.
REQ-028 A full lane shall never block pushes to other lanes.
REQ-029 routed_count shall increment by 1 per push and wrap from 0xFFFF to 0x0000.

Reset
REQ-030 While reset is high, regardless of clk: all occupancies, pointers and routed_count = 0, out_valid = 4'b0000, out_data = 0, in_ready = 0.
REQ-031 In the first cycle after reset deasserts, in_ready shall be 1.
REQ-032 Reset asserted mid-operation shall discard all buffered words immediately; no discarded word shall be presented afterwards.

Verification
REQ-033 Push 0x1234 with sel=2, all out_ready=0 -> next cycle out_valid=4'b0100, lane c = 0x1234, routed_count=1.
REQ-034 Push 0xAAAA then 0xBBBB to lane a with out_ready=0 -> in_ready=0 for sel=0 and 1 for sel=1; a push of 0xCCCC to lane b succeeds.
REQ-035 Lane a full, out_ready[0]=1 and push offered to lane a in the same cycle -> push refused, 0xAAAA popped; next cycle in_ready=1 and 0xBBBB at head.
REQ-036 Stream 8 words to lane d with out_ready[3]=1 continuously -> order preserved, one word per cycle after the first, pointers wrap correctly.
REQ-037 Assert reset asynchronously between clock edges with lanes non-empty -> outputs immediately 0, in_ready=0; after release in_ready=1 and routed_count=0.
REQ-038 Run 65536 pushes -> routed_count wraps to 0x0000.
